// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM encoding, 8N1 frame
//               constants and the clocks-per-bit derivation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // 8N1 frame shape
   localparam int C_DATA_BITS = 8;
   localparam int C_STOP_BITS = 1;

   // Receiver state encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   // Whole system clocks per serial bit (truncated)
   function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   // Counter value at the centre of a bit
   function automatic int calc_half_bit(input int clock_freq, input int baud_rate);
      return calc_clks_per_bit(clock_freq, baud_rate) / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous first-word-fall-through FIFO with a registered
//               head output. A push into a full FIFO is dropped and flagged,
//               unless a pop in the same cycle makes room for it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_overrun
);

   localparam int C_DEPTH = 1 << DEPTH_LOG2;
   localparam int C_PTR_W = DEPTH_LOG2 + 1;

   logic [DATA_W-1:0]  mem_q [C_DEPTH];
   logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               w_empty, w_full, w_do_push, w_do_pop;

   // Pointer update, push/pop qualification and next head-of-queue value
   always_comb begin
      w_empty   = (wr_ptr_q == rd_ptr_q);
      w_full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
      w_do_pop  = i_pop && !w_empty;
      // A simultaneous pop frees the slot the push needs, even when full
      w_do_push = i_push && (!w_full || w_do_pop);
      o_overrun = i_push && !w_do_push;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_do_push) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + C_PTR_W'(1);

      rd_valid_d = (wr_ptr_d != rd_ptr_d);
      // Entries already stored lie in [rd_ptr_q, wr_ptr_q); the new head is
      // either one of those or the byte being pushed right now.
      if (rd_ptr_d != wr_ptr_q) begin
         rd_data_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
      end else if (w_do_push) begin
         rd_data_d = i_push_data;
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Storage array; contents need no reset since the pointers qualify them
   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= i_push_data;
   end

   // Pointer and registered-output state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign o_rd_data  = rd_data_q;
   assign o_rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver. Synchronises RX, detects the start edge,
//               judges each bit by a 3-sample mid-bit majority vote and
//               queues bytes in a FWFT FIFO with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ      = 25125000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                   CLK,
   input  logic                   RSTb,
   input  logic                   RX,
   output logic [C_DATA_BITS-1:0] RD_DATA,
   output logic                   RD_VALID,
   input  logic                   RD_ACK,
   output logic                   FRAME_ERR,
   output logic                   OVERRUN,
   input  logic                   ERR_CLEAR
);

   localparam int C_CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int C_HALF_BIT     = calc_half_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int C_CNT_W        = $clog2(C_CLKS_PER_BIT);
   localparam int C_IDX_W        = $clog2(C_DATA_BITS);

   logic                   rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e              state_q, state_d;
   logic [C_CNT_W-1:0]     cnt_q, cnt_d;
   logic [C_IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [C_DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]             vote_q, vote_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   w_fall, w_decide, w_majority;
   logic                   w_push, w_frame_set, w_fifo_overrun;

   // Bit timing, majority sampling and frame sequencing
   always_comb begin
      w_fall      = rx_prev_q && !rx_sync_q;
      w_decide    = (cnt_q == C_CNT_W'(C_HALF_BIT + 1));
      w_majority  = (vote_q[0] && vote_q[1]) || (vote_q[0] && rx_sync_q) ||
                    (vote_q[1] && rx_sync_q);
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      vote_d      = vote_q;
      w_push      = 1'b0;
      w_frame_set = 1'b0;

      // Free-running bit-period counter while a frame is in progress; the
      // decision point recurs exactly one bit period after the previous one.
      if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
         cnt_d = (cnt_q == C_CNT_W'(C_CLKS_PER_BIT - 1)) ? '0 : cnt_q + C_CNT_W'(1);
      end
      if (cnt_q == C_CNT_W'(C_HALF_BIT - 1)) vote_d[0] = rx_sync_q;
      if (cnt_q == C_CNT_W'(C_HALF_BIT))     vote_d[1] = rx_sync_q;

      case (state_q)
         ST_IDLE: begin
            if (w_fall) begin
               state_d   = ST_START;
               cnt_d     = '0;
               bit_idx_d = '0;
            end
         end
         ST_START: begin
            if (w_decide) state_d = w_majority ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (w_decide) begin
               shift_d   = {w_majority, shift_q[C_DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + C_IDX_W'(1);
               if (bit_idx_q == C_IDX_W'(C_DATA_BITS - 1)) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leave as soon as the stop bit is judged so a back-to-back
            // start edge is not missed.
            if (w_decide) begin
               if (w_majority) begin
                  w_push  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  w_frame_set = 1'b1;
                  state_d     = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rx_sync_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Sticky flags: a set event beats a simultaneous clear
      frame_err_d = w_frame_set ? 1'b1 : (ERR_CLEAR ? 1'b0 : frame_err_q);
      overrun_d   = w_fifo_overrun ? 1'b1 : (ERR_CLEAR ? 1'b0 : overrun_q);
   end

   // Synchroniser, edge history, FSM and flag registers
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         vote_q      <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= RX;
         rx_sync_q   <= rx_meta_q;
         rx_prev_q   <= rx_sync_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         vote_q      <= vote_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .DATA_W     (C_DATA_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk         (CLK),
      .rst_n       (RSTb),
      .i_push      (w_push),
      .i_push_data (shift_q),
      .i_pop       (RD_ACK),
      .o_rd_data   (RD_DATA),
      .o_rd_valid  (RD_VALID),
      .o_overrun   (w_fifo_overrun)
   );

   assign FRAME_ERR = frame_err_q;
   assign OVERRUN   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at the default 25.125 MHz /
//               115200 baud (218 clocks per bit). Table-driven single frames
//               plus directed back-to-back, overrun, break, glitch and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int C_BIT = 218;

   logic       CLK;
   logic       RSTb;
   logic       RX;
   logic [7:0] RD_DATA;
   logic       RD_VALID;
   logic       RD_ACK;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       ERR_CLEAR;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      int         period;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[3];

   uart_rx #(
      .CLOCK_FREQ      (25125000),
      .BAUD_RATE       (115200),
      .FIFO_DEPTH_LOG2 (4)
   ) dut (
      .CLK       (CLK),
      .RSTb      (RSTb),
      .RX        (RX),
      .RD_DATA   (RD_DATA),
      .RD_VALID  (RD_VALID),
      .RD_ACK    (RD_ACK),
      .FRAME_ERR (FRAME_ERR),
      .OVERRUN   (OVERRUN),
      .ERR_CLEAR (ERR_CLEAR)
   );

   initial CLK = 1'b0;
   always #20 CLK = ~CLK;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   // Drive one 8N1 frame; caller is positioned on a falling clock edge
   task automatic send_frame(input logic [7:0] b, input int period, input logic stop);
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      RX = 1'b0;
         else if (i == 9) RX = stop;
         else             RX = b[i-1];
         repeat (period) @(negedge CLK);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Pop every expected entry in order, then confirm the FIFO is empty
   task automatic drain(input string name);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s valid[%0d]", name, i), {7'd0, RD_VALID}, 8'd1);
         check($sformatf("%s data[%0d]", name, i), RD_DATA, exp_q[i]);
         RD_ACK = 1'b1;
         @(negedge CLK);
         RD_ACK = 1'b0;
      end
      check({name, " empty"}, {7'd0, RD_VALID}, 8'd0);
   endtask

   task automatic clear_errors();
      ERR_CLEAR = 1'b1;
      @(negedge CLK);
      ERR_CLEAR = 1'b0;
   endtask

   // Hard bound on simulation length
   initial begin
      repeat (95000) @(posedge CLK);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{data: 8'h55, period: C_BIT,     stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h3C, period: C_BIT,     stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
      vecs[2] = '{data: 8'hA5, period: C_BIT + 4, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};

      RSTb = 1'b0; RX = 1'b1; RD_ACK = 1'b0; ERR_CLEAR = 1'b0;
      idle(4);
      check("reset rd_data", RD_DATA, 8'h00);
      check("reset rd_valid", {7'd0, RD_VALID}, 8'd0);
      check("reset frame_err", {7'd0, FRAME_ERR}, 8'd0);
      check("reset overrun", {7'd0, OVERRUN}, 8'd0);
      RSTb = 1'b1;
      idle(10);

      // Single frames from the table
      for (int v = 0; v < 3; v++) begin
         send_frame(vecs[v].data, vecs[v].period, vecs[v].stop);
         RX = 1'b1;
         idle(20);
         check($sformatf("vec%0d valid", v), {7'd0, RD_VALID}, {7'd0, vecs[v].exp_valid});
         if (vecs[v].exp_valid) begin
            check($sformatf("vec%0d data", v), RD_DATA, vecs[v].exp_data);
            RD_ACK = 1'b1;
            @(negedge CLK);
            RD_ACK = 1'b0;
            check($sformatf("vec%0d valid after ack", v), {7'd0, RD_VALID}, 8'd0);
         end
         check($sformatf("vec%0d frame_err", v), {7'd0, FRAME_ERR}, {7'd0, vecs[v].exp_ferr});
         check($sformatf("vec%0d overrun", v), {7'd0, OVERRUN}, 8'd0);
         clear_errors();
         check($sformatf("vec%0d frame_err cleared", v), {7'd0, FRAME_ERR}, 8'd0);
      end

      // Back-to-back frames with +/-2% bit period skew
      send_frame(8'h00, C_BIT - 4, 1'b1);
      send_frame(8'hFF, C_BIT + 4, 1'b1);
      send_frame(8'hA5, C_BIT - 4, 1'b1);
      idle(20);
      check("b2b frame_err", {7'd0, FRAME_ERR}, 8'd0);
      check("b2b overrun", {7'd0, OVERRUN}, 8'd0);
      exp_q = '{8'h00, 8'hFF, 8'hA5};
      drain("b2b");

      // Short low glitch must be rejected as a false start
      RX = 1'b0;
      idle(50);
      RX = 1'b1;
      idle(400);
      check("glitch valid", {7'd0, RD_VALID}, 8'd0);
      check("glitch frame_err", {7'd0, FRAME_ERR}, 8'd0);
      check("glitch overrun", {7'd0, OVERRUN}, 8'd0);

      // Overrun: 17 bytes into a 16-deep FIFO with no reads
      for (int i = 1; i <= 17; i++) send_frame(8'(i), C_BIT, 1'b1);
      idle(20);
      check("ovr flag", {7'd0, OVERRUN}, 8'd1);
      check("ovr head", RD_DATA, 8'h01);
      check("ovr frame_err", {7'd0, FRAME_ERR}, 8'd0);
      clear_errors();
      check("ovr cleared", {7'd0, OVERRUN}, 8'd0);

      // Push into full FIFO on the same clock as a pop. The push edge is the
      // 2076th rising edge after the start bit is driven: 3 edges to enter
      // START, then 110 + 9*218 counts to the stop decision, plus 1.
      fork
         send_frame(8'h12, C_BIT, 1'b1);
         begin
            repeat (2075) @(negedge CLK);
            RD_ACK = 1'b1;
            @(negedge CLK);
            RD_ACK = 1'b0;
         end
      join
      idle(20);
      check("simul overrun", {7'd0, OVERRUN}, 8'd0);
      check("simul head", RD_DATA, 8'h02);
      exp_q.delete();
      for (int i = 2; i <= 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h12);
      drain("simul");

      // Framing error, held-low break, then a clean frame
      send_frame(8'h3C, C_BIT, 1'b0);
      idle(5);
      check("brk frame_err", {7'd0, FRAME_ERR}, 8'd1);
      check("brk fifo empty", {7'd0, RD_VALID}, 8'd0);
      idle(30 * C_BIT);
      RX = 1'b1;
      idle(2 * C_BIT);
      send_frame(8'h3C, C_BIT, 1'b1);
      idle(20);
      check("brk frame_err sticky", {7'd0, FRAME_ERR}, 8'd1);
      exp_q = '{8'h3C};
      drain("brk");

      // Reset pulse during data bit 4 of 0x81
      RX = 1'b0;
      idle(C_BIT);
      for (int i = 0; i < 4; i++) begin
         RX = (i == 0);
         idle(C_BIT);
      end
      RX = 1'b0;
      idle(100);
      RSTb = 1'b0;
      RX   = 1'b1;
      @(negedge CLK);
      RSTb = 1'b1;
      check("rst rd_data", RD_DATA, 8'h00);
      check("rst rd_valid", {7'd0, RD_VALID}, 8'd0);
      check("rst frame_err", {7'd0, FRAME_ERR}, 8'd0);
      check("rst overrun", {7'd0, OVERRUN}, 8'd0);
      idle(50);
      send_frame(8'h81, C_BIT, 1'b1);
      idle(20);
      check("rst frame_err after", {7'd0, FRAME_ERR}, 8'd0);
      exp_q = '{8'h81};
      drain("rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
